// File: rtl/semaforo_ctrl.sv
// Sequencing controller for the two-road light FSM: input synchronizers, sensor debounce,
// green timer, round-robin emergency arbitration and maintenance all-red.
module semaforo_ctrl #(
  parameter int MIN_GREEN = 20,
  parameter int MAX_GREEN = 60,
  parameter int DEB       = 4,
  parameter int TW        = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          car_a,
  input  logic          car_b,
  input  logic [1:0]    emerg_req,
  input  logic          maint,
  input  logic [1:0]    verde,
  input  logic [1:0]    amarillo,
  output logic          ta,
  output logic          tb,
  output logic          e,
  output logic          r,
  output logic [1:0]    emerg_gnt,
  output logic [TW-1:0] phase_timer
);

  localparam int DW = (DEB < 2) ? 1 : $clog2(DEB);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB - 1);
  localparam logic [TW-1:0] MIN_T    = TW'(MIN_GREEN);
  localparam logic [TW-1:0] MAX_T    = TW'(MAX_GREEN);
  localparam logic [TW-1:0] SAT_T    = '1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MAINT = 2'd1;
  localparam logic [1:0] S_GNT_A = 2'd2;
  localparam logic [1:0] S_GNT_B = 2'd3;

  // Synchronizer bit order: {maint, emerg_req[1:0], car_b, car_a}.
  logic [4:0]    r_sync1, r_sync2;
  logic [1:0]    r_filt;
  logic [DW-1:0] r_deb_cnt [2];
  logic [1:0]    r_verde_prev;
  logic [TW-1:0] r_timer;
  logic [1:0]    r_state;
  logic          r_last;
  logic          r_ta, r_tb, r_e, r_r;
  logic [1:0]    r_gnt;

  logic [1:0] w_car, w_req;
  logic       w_maint;
  logic [1:0] w_state_nxt;
  logic       w_last_nxt;
  logic       w_t_short, w_t_long, w_ta_idle, w_tb_idle;
  logic       w_unused;

  assign w_car    = r_sync2[1:0];
  assign w_req    = r_sync2[3:2];
  assign w_maint  = r_sync2[4];
  assign w_unused = ^amarillo;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {maint, emerg_req, car_b, car_a};
      r_sync2 <= r_sync1;
    end
  end

  // NOTE: the debounce counters are an array but still get an explicit reset, since a
  // stale count would let the first post-reset glitch flip a filter early.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_filt <= '0;
      for (int i = 0; i < 2; i++) r_deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_car[i] == r_filt[i]) begin
          r_deb_cnt[i] <= '0;
        end else if (r_deb_cnt[i] == DEB_LAST) begin
          r_filt[i]    <= w_car[i];
          r_deb_cnt[i] <= '0;
        end else begin
          r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_verde_prev <= '0;
      r_timer      <= '0;
    end else begin
      r_verde_prev <= verde;
      if (verde == 2'b00 || verde != r_verde_prev) r_timer <= '0;
      else if (r_timer != SAT_T)                   r_timer <= r_timer + 1'b1;
    end
  end

  // NOTE: defaults at the top of always_comb keep every path assigned, so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    if (w_maint) begin
      w_state_nxt = S_MAINT;
    end else begin
      case (r_state)
        S_MAINT: w_state_nxt = S_IDLE;
        S_GNT_A: if (!w_req[0]) begin
          w_state_nxt = S_IDLE;
          w_last_nxt  = 1'b0;
        end
        S_GNT_B: if (!w_req[1]) begin
          w_state_nxt = S_IDLE;
          w_last_nxt  = 1'b1;
        end
        default: begin
          if (w_req == 2'b11) w_state_nxt = r_last ? S_GNT_A : S_GNT_B;
          else if (w_req[0])  w_state_nxt = S_GNT_A;
          else if (w_req[1])  w_state_nxt = S_GNT_B;
        end
      endcase
    end
  end

  // A green with no cross-road demand rests; contested greens release after MAX_GREEN.
  assign w_t_short = (r_timer < MIN_T);
  assign w_t_long  = (r_timer >= MAX_T);
  assign w_ta_idle = verde[0] & (w_t_short | (r_filt[0] & ~(r_filt[1] & w_t_long)) | ~r_filt[1]);
  assign w_tb_idle = verde[1] & (w_t_short | (r_filt[1] & ~(r_filt[0] & w_t_long)) | ~r_filt[0]);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_last  <= 1'b1;
      r_ta    <= 1'b0;
      r_tb    <= 1'b0;
      r_e     <= 1'b0;
      r_r     <= 1'b0;
      r_gnt   <= 2'b00;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      case (w_state_nxt)
        S_MAINT: begin r_r <= 1'b1; r_e <= 1'b0; r_ta <= 1'b0; r_tb <= 1'b0; r_gnt <= 2'b00; end
        S_GNT_A: begin r_r <= 1'b0; r_e <= 1'b1; r_ta <= 1'b1; r_tb <= 1'b0; r_gnt <= 2'b01; end
        S_GNT_B: begin r_r <= 1'b0; r_e <= 1'b0; r_ta <= 1'b0; r_tb <= 1'b1; r_gnt <= 2'b10; end
        default: begin r_r <= 1'b0; r_e <= 1'b0; r_ta <= w_ta_idle; r_tb <= w_tb_idle; r_gnt <= 2'b00; end
      endcase
    end
  end

  assign ta          = r_ta;
  assign tb          = r_tb;
  assign e           = r_e;
  assign r           = r_r;
  assign emerg_gnt   = r_gnt;
  assign phase_timer = r_timer;

endmodule

// File: tb/tb_semaforo_ctrl.sv
// Directed plus randomized bench for semaforo_ctrl, checked every cycle against a
// behavioural model built from sample histories and run lengths.
module tb_semaforo_ctrl;

  localparam int MIN_G = 20;
  localparam int MAX_G = 60;
  localparam int DEB_N = 4;
  localparam int TW_N  = 8;
  localparam int SAT   = (1 << TW_N) - 1;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            car_a = 1'b0, car_b = 1'b0, maint = 1'b0;
  logic [1:0]      emerg_req = 2'b00, verde = 2'b00, amarillo = 2'b00;
  logic            ta, tb, e, r;
  logic [1:0]      emerg_gnt;
  logic [TW_N-1:0] phase_timer;

  always #5 clk = ~clk;

  semaforo_ctrl #(.MIN_GREEN(MIN_G), .MAX_GREEN(MAX_G), .DEB(DEB_N), .TW(TW_N)) dut (
    .clk(clk), .reset(reset), .car_a(car_a), .car_b(car_b), .emerg_req(emerg_req),
    .maint(maint), .verde(verde), .amarillo(amarillo), .ta(ta), .tb(tb), .e(e), .r(r),
    .emerg_gnt(emerg_gnt), .phase_timer(phase_timer)
  );

  int n_assert = 0;
  int n_fail   = 0;

  typedef enum {OWN_NONE, OWN_MAINT, OWN_A, OWN_B} owner_t;
  typedef bit bq_t[$];

  owner_t     m_owner = OWN_NONE;
  bit         m_last = 1'b1;
  logic [4:0] m_sync_q[$];
  bq_t        m_win_a, m_win_b;
  bit         m_fa, m_fb;
  logic [1:0] m_prev_verde;
  int         m_run;
  bit         x_ta, x_tb, x_e, x_r;
  logic [1:0] x_gnt;
  int         x_timer;

  function automatic bit all_differ(input bq_t q, input bit f);
    foreach (q[i]) if (q[i] == f) return 1'b0;
    return 1'b1;
  endfunction

  // One clock edge of the reference: inputs seen by the logic are the raw samples from
  // two edges ago; a filter flips once the last DEB seen samples all disagree with it.
  task automatic model_step();
    logic [4:0] seen;
    bit [1:0]   req;
    int         t;
    bit         fa, fb, side;
    if (!reset) begin
      m_sync_q = '{5'd0, 5'd0};
      m_win_a.delete();
      m_win_b.delete();
      m_fa = 0; m_fb = 0; m_prev_verde = 2'b00; m_run = 0;
      m_owner = OWN_NONE; m_last = 1'b1;
      x_ta = 0; x_tb = 0; x_e = 0; x_r = 0; x_gnt = 2'b00; x_timer = 0;
      return;
    end
    seen = m_sync_q.pop_front();
    m_sync_q.push_back({maint, emerg_req, car_b, car_a});
    req = seen[3:2];
    t = x_timer; fa = m_fa; fb = m_fb;

    if (seen[4]) m_owner = OWN_MAINT;
    else if (m_owner == OWN_MAINT) m_owner = OWN_NONE;
    else if (m_owner == OWN_A && !req[0]) begin m_owner = OWN_NONE; m_last = 1'b0; end
    else if (m_owner == OWN_B && !req[1]) begin m_owner = OWN_NONE; m_last = 1'b1; end
    else if (m_owner == OWN_NONE && req != 2'b00) begin
      side = (req == 2'b11) ? !m_last : req[1];
      m_owner = side ? OWN_B : OWN_A;
    end

    x_e   = (m_owner == OWN_A);
    x_r   = (m_owner == OWN_MAINT);
    x_gnt = {m_owner == OWN_B, m_owner == OWN_A};
    case (m_owner)
      OWN_A:     begin x_ta = 1; x_tb = 0; end
      OWN_B:     begin x_ta = 0; x_tb = 1; end
      OWN_MAINT: begin x_ta = 0; x_tb = 0; end
      default: begin
        x_ta = verde[0] && (t < MIN_G || (fa && !(fb && t >= MAX_G)) || !fb);
        x_tb = verde[1] && (t < MIN_G || (fb && !(fa && t >= MAX_G)) || !fa);
      end
    endcase

    m_win_a.push_back(seen[0]);
    if (m_win_a.size() > DEB_N) void'(m_win_a.pop_front());
    if (m_win_a.size() == DEB_N && all_differ(m_win_a, m_fa)) m_fa = !m_fa;
    m_win_b.push_back(seen[1]);
    if (m_win_b.size() > DEB_N) void'(m_win_b.pop_front());
    if (m_win_b.size() == DEB_N && all_differ(m_win_b, m_fb)) m_fb = !m_fb;

    // Timer = length of the current run of an unchanged nonzero verde, minus one, saturated.
    if (verde == 2'b00)             m_run = 0;
    else if (verde == m_prev_verde) m_run = m_run + 1;
    else                            m_run = 1;
    m_prev_verde = verde;
    x_timer = (m_run == 0) ? 0 : ((m_run - 1 > SAT) ? SAT : m_run - 1);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("ta", ta, x_ta);
    chk("tb", tb, x_tb);
    chk("e", e, x_e);
    chk("r", r, x_r);
    chk("emerg_gnt", emerg_gnt, x_gnt);
    chk("phase_timer", phase_timer, x_timer);
  endtask

  initial begin
    // Reset with junk on the inputs: everything must read zero.
    reset = 1'b0; car_a = 1'b1; emerg_req = 2'b11; maint = 1'b1; verde = 2'b01;
    tick(); tick();
    chk("rst_outs", {ta, tb, e, r, emerg_gnt}, 6'd0);
    chk("rst_timer", phase_timer, 0);
    reset = 1'b1; emerg_req = 2'b00; maint = 1'b0;

    // Avenue demand only: green rests and the timer saturates.
    car_a = 1'b1; car_b = 1'b0; verde = 2'b01;
    repeat (300) tick();
    chk("sat_timer", phase_timer, SAT);
    chk("rest_ta", ta, 1);

    // Both roads demand: release at MAX_GREEN.
    car_b = 1'b1; verde = 2'b00; tick(); verde = 2'b01;
    repeat (80) tick();
    chk("maxg_drop", ta, 0);

    // Only the boulevard demands: release at MIN_GREEN.
    car_a = 1'b0; verde = 2'b00; tick(); verde = 2'b01;
    repeat (40) tick();
    chk("ming_drop", ta, 0);

    // Glitch rejection on car_b with the avenue green long past MAX_GREEN.
    car_a = 1'b1; car_b = 1'b0;
    repeat (70) tick();
    chk("pre_glitch", ta, 1);
    car_b = 1'b1; repeat (3) tick(); car_b = 1'b0;
    repeat (10) tick();
    chk("glitch3", ta, 1);
    car_b = 1'b1; repeat (4) tick(); car_b = 1'b0;
    repeat (3) tick();
    chk("glitch4", ta, 0);
    repeat (10) tick();

    // Emergency tie after reset goes to the avenue; dropping it hands over via one IDLE cycle.
    reset = 1'b0; tick(); reset = 1'b1;
    car_a = 1'b0; car_b = 1'b0; verde = 2'b00;
    emerg_req = 2'b11;
    repeat (3) tick();
    chk("tie_gnt", emerg_gnt, 2'b01);
    chk("tie_e", e, 1);
    emerg_req = 2'b10;
    repeat (3) tick();
    chk("handover_idle", emerg_gnt, 2'b00);
    tick();
    chk("handover_gnt", emerg_gnt, 2'b10);
    chk("handover_tb", {ta, tb}, 2'b01);

    // Maintenance preempts the boulevard grant, which returns afterwards.
    maint = 1'b1;
    repeat (3) tick();
    chk("maint_r", r, 1);
    chk("maint_outs", {ta, tb, e, emerg_gnt}, 5'd0);
    maint = 1'b0;
    repeat (3) tick();
    chk("maint_idle", emerg_gnt, 2'b00);
    tick();
    chk("maint_regrant", emerg_gnt, 2'b10);

    // Reset in the middle of an avenue grant.
    emerg_req = 2'b01;
    repeat (5) tick();
    chk("pre_rst_gnt", emerg_gnt, 2'b01);
    reset = 1'b0; tick();
    chk("midrst_outs", {ta, tb, e, r, emerg_gnt}, 6'd0);
    reset = 1'b1; emerg_req = 2'b11;
    repeat (4) tick();
    chk("post_rst_tie", emerg_gnt, 2'b01);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0)  car_a = ~car_a;
      if ($urandom_range(0, 7) == 0)  car_b = ~car_b;
      if ($urandom_range(0, 19) == 0) emerg_req[0] = ~emerg_req[0];
      if ($urandom_range(0, 19) == 0) emerg_req[1] = ~emerg_req[1];
      if ($urandom_range(0, 59) == 0) maint = ~maint;
      if ($urandom_range(0, 29) == 0) verde = 2'($urandom_range(0, 2));
      amarillo = 2'($urandom_range(0, 3));
      reset = ($urandom_range(0, 499) != 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/semaforo_ctrl.md
# semaforo_ctrl

Sequencing controller that drives the TA/TB/E/R inputs of the two-road traffic-light FSM (avenue = index 0, boulevard = index 1). It debounces the car sensors and enforces minimum and maximum green times using the FSM's light outputs as feedback. It also arbitrates two emergency-vehicle requests round-robin and gives a maintenance all-red request priority over everything. It sits between the raw field inputs and the light FSM, on the same clock.

## Interface
- `MIN_GREEN`, default 20: cycles a green is held unconditionally.
- `MAX_GREEN`, default 60: cycles after which a green with cross-road demand is released; must satisfy MIN_GREEN ≤ MAX_GREEN < 2^TW.
- `DEB`, default 4: consecutive stable cycles required to change a filtered car-sensor value (≥1).
- `TW`, default 8: width of the green timer.
- Reset: one clock, synchronous, active-low. The ports follow the codebase's clk/reset naming.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-low reset (0 = reset).
- `car_a`, `car_b`  in  1  raw car sensors, avenue / boulevard (asynchronous).
- `emerg_req`  in  2  emergency requests, [0] avenue, [1] boulevard (asynchronous).
- `maint`  in  1  maintenance all-red request (asynchronous).
- `verde`, `amarillo`  in  2 each  light feedback from the light FSM.
- `ta`, `tb`, `e`, `r`  out  1 each  registered drives to the light FSM.
- `emerg_gnt`  out  2  one-hot emergency grant, [0] avenue, [1] boulevard.
- `phase_timer`  out  TW  cycles spent in the current green.

## Operation
- Synchronizers:
  - `car_a`, `car_b`, `emerg_req[1:0]` and `maint` each pass through a 2-FF synchronizer.
  - The rest of the block uses only the synchronized values.
- Debounce, per car sensor:
  - A counter increments while the synchronized value differs from the filtered value and clears when they match.
  - When the count reaches DEB, the filtered value takes the synchronized value and the counter clears.
- Green timer:
  - Clears when `verde == 2'b00` or when `verde` differs from its previous-cycle value.
  - Otherwise it increments, saturating at 2^TW−1.
  - `phase_timer` shows this timer directly.
- Arbiter FSM, states IDLE, MAINT, GNT_A, GNT_B; `last` is a 1-bit pointer:
  - Any state → MAINT when `maint` (synced) = 1. This has highest priority and is re-evaluated every cycle.
  - MAINT → IDLE when `maint` = 0.
  - IDLE with both requests → grant the side ≠ `last`. With one request → grant that side.
  - GNT_x → IDLE when `req[x]` drops; `last` ← x. A grant is held as long as its request stays high, with no preemption by the other request.
- Outputs, registered and computed from the next state:
  - MAINT: r=1, e=0, ta=0, tb=0, emerg_gnt=00.
  - GNT_A: e=1, ta=1, tb=0, r=0, emerg_gnt=01. E steers the light FSM back to avenue green.
  - GNT_B: e=0, ta=0, tb=1, r=0, emerg_gnt=10. This forces the light FSM through avenue yellow to boulevard green and holds it there.
  - IDLE: e=0, r=0, emerg_gnt=00, with:
    - ta = verde[0] & ( T<MIN_GREEN | (fa & ¬(fb & T≥MAX_GREEN)) | ¬fb )
    - tb = verde[1] & ( T<MIN_GREEN | (fb & ¬(fa & T≥MAX_GREEN)) | ¬fa )
    - where T = green timer value and fa/fb = filtered sensors. A green with no cross-road demand rests.
- Comparisons are unsigned TW-bit. The timer saturates and never wraps.

## Timing
- Reset (reset=0 at a rising edge):
  - Every register clears: ta, tb, e, r, emerg_gnt, phase_timer = 0, state = IDLE, filters = 0, debounce counters = 0, synchronizers = 0.
  - Exception: `last` = 1, so the first tie is won by the avenue.
  - Reset asserted mid-grant or mid-maintenance drops all outputs to 0 at that same edge.
- Latency:
  - `emerg_req`/`maint`: first sampled at edge n, the output changes after edge n+2.
  - Car sensors: 2 cycles of synchronizer plus DEB cycles, plus 1 registered output cycle.
  - `verde` change → timer cleared after the same edge. ta/tb respond at the next edge.
- Simultaneous events:
  - `maint` wins over any request.
  - Both requests rising in the same cycle go to the side ≠ `last`.
  - A request that drops and another that is pending in the same cycle: IDLE for 1 cycle, then grant the pending side.

## Test plan
- Reset, then car_a=1, car_b=0, verde=01 held: ta=1 indefinitely; phase_timer saturates at 255 with no wrap.
- verde=01, car_a=1, car_b=1: ta=1 until phase_timer ≥ 60, then ta=0 on the following edge. car_a=0 with car_b=1: ta drops once phase_timer ≥ 20.
- Glitch car_b high for 3 cycles (DEB=4): no change in tb/ta. High for 4 cycles: the filtered value flips.
- emerg_req=11 after reset: emerg_gnt=01, e=1. Drop [0]: one cycle emerg_gnt=00, then 10 with ta=0, tb=1.
- maint=1 during GNT_B: r=1, emerg_gnt=00, ta=tb=e=0 after 3 edges. maint=0: IDLE, then GNT_B re-granted if req[1] is still high.
- reset=0 asserted mid-GNT_A: all outputs 0 at that edge. Release: IDLE, with `last`=1.
